// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-unit state encoding, word width and
// the signed-overflow rule used by both the adder and the subtractor flags.
package arith_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Overflow of a +/- b: the effective operand signs agree but the result sign differs.
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic eff_b_msb;
    eff_b_msb = b_msb ^ is_sub;
    return (a_msb == eff_b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// W-bit full subtractor: {bout, d} = x - y - bin evaluated at W+1 bits.
module digit_subtractor #(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] res_s;

  // Extended-width difference; the top bit is the borrow out.
  always_comb begin
    res_s = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  end

  assign d    = res_s[W-1:0];
  assign bout = res_s[W];

endmodule

// File: rtl/serial_32_subtractor.sv
// Digit-serial subtractor: diff = a - b, DIGIT bits per clock LSB first,
// with a start/done handshake and flags held until the next result.
module serial_32_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e                   state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [WIDTH-1:0]         a_sh_r;
  logic [WIDTH-1:0]         b_sh_r;
  // Only the WIDTH-DIGIT most recent result bits need storing; the newest digit is combinational.
  logic [WIDTH-DIGIT-1:0]   diff_sh_r;
  logic                     bin_r;
  logic                     a_msb_r;
  logic                     b_msb_r;
  logic                     busy_r;
  logic                     done_r;
  logic [WIDTH-1:0]         diff_r;
  logic                     borrow_r;
  logic                     overflow_r;
  logic                     zero_r;

  logic [DIGIT-1:0]         d_s;
  logic                     bout_s;
  logic [WIDTH-1:0]         diff_next_s;

  digit_subtractor #(
    .W(DIGIT)
  ) u_digit (
    .x   (a_sh_r[DIGIT-1:0]),
    .y   (b_sh_r[DIGIT-1:0]),
    .bin (bin_r),
    .d   (d_s),
    .bout(bout_s)
  );

  // Result word as it stands after this cycle's digit enters at the top.
  always_comb begin
    diff_next_s = {d_s, diff_sh_r};
  end

  // Handshake FSM, shift datapath and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      diff_sh_r  <= '0;
      bin_r      <= 1'b0;
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh_r    <= a;
            b_sh_r    <= b;
            a_msb_r   <= a[WIDTH-1];
            b_msb_r   <= b[WIDTH-1];
            bin_r     <= 1'b0;
            cnt_r     <= '0;
            diff_sh_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= S_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_r    <= a_sh_r >> DIGIT;
          b_sh_r    <= b_sh_r >> DIGIT;
          diff_sh_r <= diff_next_s[WIDTH-1:DIGIT];
          bin_r     <= bout_s;
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            diff_r     <= diff_next_s;
            borrow_r   <= bout_s;
            overflow_r <= signed_ovf(1'b1, a_msb_r, b_msb_r, diff_next_s[WIDTH-1]);
            zero_r     <= (diff_next_s == '0);
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= S_DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= S_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign diff     = diff_r;
  assign borrow   = borrow_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;

endmodule

// File: tb/tb_serial_32_subtractor.sv
// Self-checking bench: DIGIT=1 and DIGIT=8 instances driven from a vector
// table, random operands against an arithmetic model, and handshake corners.
module tb_serial_32_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        start_v  [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [31:0] diff_v   [2];
  logic        borrow_v [2];
  logic        ovf_v    [2];
  logic        zero_v   [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  serial_32_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]),
    .borrow(borrow_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0])
  );

  serial_32_subtractor #(.WIDTH(32), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]),
    .borrow(borrow_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 32 : 4;
  endfunction

  // Reference: plain unsigned and wide signed arithmetic.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] d, output logic br,
                                output logic ov, output logic z);
    longint sd;
    d  = x - y;
    br = (x < y);
    sd = longint'($signed(x)) - longint'($signed(y));
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    z  = (d == 32'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input int i, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
  endtask

  // Counts edges after acceptance until done; -1 if the budget expires.
  task automatic wait_done(input int i, output int lat, output logic clash);
    lat = -1;
    clash = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done_v[i] && busy_v[i]) clash = 1'b1;
      if (done_v[i]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_check(input int i, input string name, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] ed,
                           input logic eb, input logic eo, input logic ez);
    int   lat;
    logic clash;
    start_op(i, av, bv);
    a = ~av;
    b = $urandom;
    wait_done(i, lat, clash);
    check($sformatf("%s.d%0d.lat", name, i), 32'(lat), 32'(lat_of(i)));
    check($sformatf("%s.d%0d.diff", name, i), diff_v[i], ed);
    check($sformatf("%s.d%0d.borrow", name, i), 32'(borrow_v[i]), 32'(eb));
    check($sformatf("%s.d%0d.ovf", name, i), 32'(ovf_v[i]), 32'(eo));
    check($sformatf("%s.d%0d.zero", name, i), 32'(zero_v[i]), 32'(ez));
    check($sformatf("%s.d%0d.clash", name, i), 32'(clash), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("%s.d%0d.done_pulse", name, i), 32'(done_v[i]), 32'd0);
    check($sformatf("%s.d%0d.idle_busy", name, i), 32'(busy_v[i]), 32'd0);
  endtask

  // Start held high across two operations, plus a start pulse during the second RUN.
  task automatic back_to_back(input int i);
    logic [31:0] a1, b1, a2, b2, d1, d2;
    logic        br1, ov1, z1, br2, ov2, z2, clash, stable;
    int          lat;
    a1 = 32'd2345;      b1 = 32'd12;
    a2 = 32'h7FFFFFFF;  b2 = 32'hFFFFFFFF;
    model(a1, b1, d1, br1, ov1, z1);
    model(a2, b2, d2, br2, ov2, z2);
    @(negedge clk);
    a = a1;
    b = b1;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    a = a2;
    b = b2;
    wait_done(i, lat, clash);
    check($sformatf("b2b.d%0d.lat1", i), 32'(lat), 32'(lat_of(i)));
    check($sformatf("b2b.d%0d.diff1", i), diff_v[i], d1);
    @(posedge clk);
    #1;
    check($sformatf("b2b.d%0d.accept_busy", i), 32'(busy_v[i]), 32'd1);
    check($sformatf("b2b.d%0d.accept_done", i), 32'(done_v[i]), 32'd0);
    stable = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 2) begin
        start_v[i] = 1'b1;
        a = 32'd5;
        b = 32'd3;
      end else begin
        start_v[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_v[i]) begin
        lat = k;
        break;
      end
      if (diff_v[i] !== d1 || borrow_v[i] !== br1) stable = 1'b0;
    end
    start_v[i] = 1'b0;
    check($sformatf("b2b.d%0d.hold_stable", i), 32'(stable), 32'd1);
    check($sformatf("b2b.d%0d.lat2", i), 32'(lat), 32'(lat_of(i)));
    check($sformatf("b2b.d%0d.diff2", i), diff_v[i], d2);
    check($sformatf("b2b.d%0d.ovf2", i), 32'(ovf_v[i]), 32'(ov2));
    check($sformatf("b2b.d%0d.borrow2", i), 32'(borrow_v[i]), 32'(br2));
    @(posedge clk);
    #1;
    check($sformatf("b2b.d%0d.pulse_ignored", i), 32'(busy_v[i]), 32'd0);
  endtask

  task automatic reset_mid_run(input int i);
    int rc;
    int pulses;
    rc = (i == 0) ? 10 : 2;
    start_op(i, 32'd2345, 32'd12);
    repeat (rc - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("rstmid.d%0d.busy", i), 32'(busy_v[i]), 32'd0);
    check($sformatf("rstmid.d%0d.diff", i), diff_v[i], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_v[i]) pulses++;
    end
    check($sformatf("rstmid.d%0d.no_done", i), 32'(pulses), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] av, bv, ed;
    logic        eb, eo, ez;

    tbl[0] = '{32'd2345,      32'd12,          32'd2333,        1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd502,       32'd23,          32'd479,         1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'hAAAAAAAA,  32'hAAAAAAAA,    32'h00000000,    1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'h00000000,  32'hAAAAAAAA,    32'h55555556,    1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h00000000,  32'h00000001,    32'hFFFFFFFF,    1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h7FFFFFFF,  32'hFFFFFFFF,    32'h80000000,    1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h80000000,  32'h00000001,    32'h7FFFFFFF,    1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h12345678,  32'h00000000,    32'h12345678,    1'b0, 1'b0, 1'b0};
    tbl[8] = '{32'h00000000,  32'h00000000,    32'h00000000,    1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset.d%0d.busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset.d%0d.done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("reset.d%0d.diff", i), diff_v[i], 32'd0);
      check($sformatf("reset.d%0d.borrow", i), 32'(borrow_v[i]), 32'd0);
      check($sformatf("reset.d%0d.ovf", i), 32'(ovf_v[i]), 32'd0);
      check($sformatf("reset.d%0d.zero", i), 32'(zero_v[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 2; i++) begin
        run_check(i, $sformatf("vec%0d", v), tbl[v].a, tbl[v].b,
                  tbl[v].d, tbl[v].br, tbl[v].ov, tbl[v].z);
      end
    end

    for (int n = 0; n < 20; n++) begin
      av = $urandom;
      bv = (n % 5 == 0) ? av : $urandom;
      model(av, bv, ed, eb, eo, ez);
      for (int i = 0; i < 2; i++) begin
        run_check(i, $sformatf("rnd%0d", n), av, bv, ed, eb, eo, ez);
      end
    end

    for (int i = 0; i < 2; i++) begin
      back_to_back(i);
    end

    for (int i = 0; i < 2; i++) begin
      reset_mid_run(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_32_subtractor.md
Name: serial_32_subtractor

Overview:
- Multi-cycle 32-bit subtractor, the counterpart of the team's combinational 32-bit adder: computes diff = a - b one digit per clock, least-significant digit first, using a registered borrow chain.
- Start/done handshake; results held stable until the next accepted start.
- Used in the arithmetic datapath where area matters more than latency.
- Doubles as the golden cross-check for adder results (a + b - b == a).

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; legal values 1, 2, 4, 8.
- STEPS, WIDTH/DIGIT, derived local constant; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- busy  output  1  high while state=RUN
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  unsigned borrow out (a < b unsigned)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE; cnt=0; borrow chain=0.
  - busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0.
  - Reset overrides everything, including mid-RUN: the partial result is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a_sh=a, b_sh=b and a_msb=a[WIDTH-1], b_msb=b[WIDTH-1]; clear the borrow flop and cnt; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - {bout, d} = a_sh[DIGIT-1:0] - b_sh[DIGIT-1:0] - bin, evaluated at DIGIT+1 bits.
  - diff_sh is shifted right by DIGIT, with d entering at the top.
  - a_sh and b_sh are shifted right by DIGIT.
  - The borrow flop takes bout; cnt increments.
  - On the edge where cnt==STEPS-1: go to DONE.
  - start is ignored throughout RUN.
- Outputs on the RUN->DONE edge:
  - diff=diff_sh including the final digit; borrow=final bout.
  - overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
  - zero = (diff == 0); done=1.
- DONE: lasts exactly one cycle.
  - If start=1: behave as IDLE accepting a new operation (go straight to RUN).
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0; done=1 in the cycle after edge E_STEPS, i.e. 32 cycles for DIGIT=1 and 4 cycles for DIGIT=8.
  - Throughput is one result per STEPS+1 cycles with start held high.
- Hold rule: diff, borrow, overflow and zero hold their values until the next RUN->DONE edge or reset. They do not change during RUN.
- busy=1 exactly in RUN; done is never high while busy=1.
- Mid-operation input changes: a and b changing during RUN have no effect, since only the latched copies are used.
- Boundaries: b=0 gives diff=a, borrow=0. a==b gives diff=0, zero=1, borrow=0. 0 - 1 gives diff=all ones, borrow=1, overflow=0.

Decomposition:
- Shared package arith_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - WORD_W=32;
  - the overflow-rule function (shared with the adder's flag logic).
- One combinational sub-module, digit_subtractor (DIGIT-bit full subtractor: inputs x, y, bin; outputs d, bout), instantiated once.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset mid-RUN: start with a=2345, b=12; assert rst at cycle 10. Required: busy=0 and diff=0 the next cycle; no done pulse follows.
- Basic: a=2345, b=12, pulse start. Required: done at cycle 32; diff=2333, borrow=0, overflow=0, zero=0. Repeat with a=502, b=23: required diff=479.
- Equal operands: a=b=0xAAAAAAAA. Required: diff=0, zero=1, borrow=0, overflow=0.
- Borrow without overflow: a=0, b=0xAAAAAAAA. Required: diff=0x55555556, borrow=1, overflow=0. Also a=0, b=1: required diff=0xFFFFFFFF, borrow=1.
- Signed overflow: a=0x7FFFFFFF, b=0xFFFFFFFF. Required: diff=0x80000000, overflow=1, borrow=1. Also a=0x80000000, b=1: required diff=0x7FFFFFFF, overflow=1, borrow=0.
- Handshake and DIGIT: start held high across two operations. Required: the second operation is accepted in the DONE cycle; a start pulsed during RUN is ignored; held outputs stay stable during the second RUN. Rerun the suite with DIGIT=8: required done at cycle 4 with identical results.
